// File: rtl/fg_prog_sequencer_pkg.sv
// fg_prog_pkg: shared types for the floating-gate programming sequencer.
// Holds field widths, mode/status/state enums and the latched command bundle.
package fg_prog_pkg;

    localparam int ISLAND_BITS = 1;
    localparam int ROW_BITS    = 6;
    localparam int COL_BITS    = 6;
    localparam int PULSE_W     = 16;
    localparam int COUNT_W     = 8;

    typedef enum logic [1:0] {
        MODE_INJ  = 2'b00,
        MODE_TUN  = 2'b01,
        MODE_MEAS = 2'b10,
        MODE_ILL  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_ABORT   = 2'b01,
        ST_ILLEGAL = 2'b10
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SETTLE,
        S_PULSE,
        S_RECOVER,
        S_RESP,
        S_DRAIN
    } state_e;

    typedef struct packed {
        logic [ISLAND_BITS-1:0] island;
        logic [ROW_BITS-1:0]    row;
        logic [COL_BITS-1:0]    col;
        mode_e                  mode;
        logic [PULSE_W-1:0]     len;
        logic [COUNT_W-1:0]     cnt;
    } cmd_t;

    // Zero-length pulses are only meaningful for measure windows.
    function automatic logic cmd_illegal(cmd_t c);
        return (c.mode == MODE_ILL) ||
               ((c.mode != MODE_MEAS) && (c.len == '0));
    endfunction

endpackage

// File: rtl/fg_prog_sequencer_if.sv
// fg_prog_sequencer_if: host command/response handshake bundle.
// master = host (drives cmd_*, abort, rsp_ready); slave = sequencer.
interface fg_prog_sequencer_if;
    import fg_prog_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [ISLAND_BITS-1:0] cmd_island;
    logic [ROW_BITS-1:0]    cmd_row;
    logic [COL_BITS-1:0]    cmd_col;
    logic [1:0]             cmd_mode;
    logic [PULSE_W-1:0]     cmd_pulse_len;
    logic [COUNT_W-1:0]     cmd_pulse_cnt;
    logic                   abort;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_status;
    logic [COUNT_W-1:0]     rsp_pulses;

    modport master (
        output cmd_valid, cmd_island, cmd_row, cmd_col,
        output cmd_mode, cmd_pulse_len, cmd_pulse_cnt,
        output abort, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_status, rsp_pulses
    );

    modport slave (
        input  cmd_valid, cmd_island, cmd_row, cmd_col,
        input  cmd_mode, cmd_pulse_len, cmd_pulse_cnt,
        input  abort, rsp_ready,
        output cmd_ready, rsp_valid, rsp_status, rsp_pulses
    );

endinterface

// File: rtl/fg_prog_sequencer_timer.sv
// fg_prog_timer: loadable down-counter; done while the count is zero.
// Ports: clk, rst, load, load_val (interval-1), done.
module fg_prog_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// fg_prog_sequencer: FPAA floating-gate programming sequencer.
// Ports: clk, rst, bus (cmd/rsp handshake, abort), decoder addresses,
// decode_en, prog_mode, drain_sel_en, vinj/vtun strobes, meas_en, busy.
module fg_prog_sequencer
    import fg_prog_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int RECOVER_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fg_prog_sequencer_if.slave     bus,
    output logic [ISLAND_BITS-1:0] island_sel,
    output logic [ROW_BITS-1:0]    row_addr,
    output logic [COL_BITS-1:0]    col_addr,
    output logic                   decode_en,
    output logic                   prog_mode,
    output logic                   drain_sel_en,
    output logic                   vinj_pulse,
    output logic                   vtun_pulse,
    output logic                   meas_en,
    output logic                   busy
);

    localparam logic [PULSE_W-1:0] SETTLE_LD =
        PULSE_W'(SETTLE_CYCLES - 1);
    localparam logic [PULSE_W-1:0] REC_LD =
        PULSE_W'(RECOVER_CYCLES - 1);

    state_e             state;
    cmd_t               cmd;
    cmd_t               cmd_in;
    logic [COUNT_W-1:0] pulses;
    logic               tmr_load;
    logic [PULSE_W-1:0] tmr_val;
    logic               tmr_done;
    logic [PULSE_W-1:0] len_ld;
    logic               accept;

    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign busy   = (state != S_IDLE);

    always_comb begin
        cmd_in        = '0;
        cmd_in.island = bus.cmd_island;
        cmd_in.row    = bus.cmd_row;
        cmd_in.col    = bus.cmd_col;
        cmd_in.mode   = mode_e'(bus.cmd_mode);
        cmd_in.len    = bus.cmd_pulse_len;
        cmd_in.cnt    = bus.cmd_pulse_cnt;
    end

    // Measure windows of length 0 are clamped to a single cycle.
    assign len_ld = (cmd.len == '0) ? '0 : cmd.len - 1'b1;

    // Timer reload on every interval boundary; it free-runs otherwise.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = REC_LD;
        unique case (state)
            S_SETUP: begin
                tmr_load = 1'b1;
                tmr_val  = bus.abort ? REC_LD : SETTLE_LD;
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    tmr_load = 1'b1;
                end else if (tmr_done && cmd.cnt != '0) begin
                    tmr_load = 1'b1;
                    tmr_val  = len_ld;
                end
            end
            S_PULSE: begin
                tmr_load = bus.abort || tmr_done;
            end
            S_RECOVER: begin
                if (bus.abort) begin
                    tmr_load = 1'b1;
                end else if (tmr_done && pulses != cmd.cnt) begin
                    tmr_load = 1'b1;
                    tmr_val  = len_ld;
                end
            end
            default: ;
        endcase
    end

    fg_prog_timer #(.W(PULSE_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cmd            <= '0;
            pulses         <= '0;
            bus.cmd_ready  <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_status <= 2'b00;
            bus.rsp_pulses <= '0;
            island_sel     <= '0;
            row_addr       <= '0;
            col_addr       <= '0;
            decode_en      <= 1'b0;
            prog_mode      <= 1'b0;
            drain_sel_en   <= 1'b0;
            vinj_pulse     <= 1'b0;
            vtun_pulse     <= 1'b0;
            meas_en        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (accept) begin
                        bus.cmd_ready <= 1'b0;
                        cmd           <= cmd_in;
                        pulses        <= '0;
                        if (cmd_illegal(cmd_in)) begin
                            state          <= S_RESP;
                            bus.rsp_valid  <= 1'b1;
                            bus.rsp_status <= ST_ILLEGAL;
                            bus.rsp_pulses <= '0;
                        end else begin
                            state        <= S_SETUP;
                            island_sel   <= cmd_in.island;
                            row_addr     <= cmd_in.row;
                            col_addr     <= cmd_in.col;
                            decode_en    <= 1'b1;
                            prog_mode    <= 1'b1;
                            drain_sel_en <= (cmd_in.mode != MODE_TUN);
                        end
                    end
                end
                S_SETUP: begin
                    state <= bus.abort ? S_DRAIN : S_SETTLE;
                end
                S_SETTLE: begin
                    if (bus.abort) begin
                        state <= S_DRAIN;
                    end else if (tmr_done) begin
                        if (cmd.cnt == '0) begin
                            state          <= S_RESP;
                            bus.rsp_valid  <= 1'b1;
                            bus.rsp_status <= ST_OK;
                            bus.rsp_pulses <= pulses;
                            decode_en      <= 1'b0;
                            prog_mode      <= 1'b0;
                            drain_sel_en   <= 1'b0;
                        end else begin
                            state      <= S_PULSE;
                            vinj_pulse <= (cmd.mode == MODE_INJ);
                            vtun_pulse <= (cmd.mode == MODE_TUN);
                            meas_en    <= (cmd.mode == MODE_MEAS);
                        end
                    end
                end
                S_PULSE: begin
                    if (bus.abort || tmr_done) begin
                        vinj_pulse <= 1'b0;
                        vtun_pulse <= 1'b0;
                        meas_en    <= 1'b0;
                    end
                    // A truncated pulse is not counted.
                    if (bus.abort) begin
                        state <= S_DRAIN;
                    end else if (tmr_done) begin
                        state  <= S_RECOVER;
                        pulses <= pulses + 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (bus.abort) begin
                        state <= S_DRAIN;
                    end else if (tmr_done) begin
                        if (pulses == cmd.cnt) begin
                            state          <= S_RESP;
                            bus.rsp_valid  <= 1'b1;
                            bus.rsp_status <= ST_OK;
                            bus.rsp_pulses <= pulses;
                            decode_en      <= 1'b0;
                            prog_mode      <= 1'b0;
                            drain_sel_en   <= 1'b0;
                        end else begin
                            state      <= S_PULSE;
                            vinj_pulse <= (cmd.mode == MODE_INJ);
                            vtun_pulse <= (cmd.mode == MODE_TUN);
                            meas_en    <= (cmd.mode == MODE_MEAS);
                        end
                    end
                end
                S_DRAIN: begin
                    if (tmr_done) begin
                        state          <= S_RESP;
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_status <= ST_ABORT;
                        bus.rsp_pulses <= pulses;
                        decode_en      <= 1'b0;
                        prog_mode      <= 1'b0;
                        drain_sel_en   <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= S_IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// tb_fg_prog_sequencer: directed bench for fg_prog_sequencer.
// Traces strobes per cycle after accept and compares to hand-built patterns.
module tb_fg_prog_sequencer;
    import fg_prog_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fg_prog_sequencer_if bus();

    logic [ISLAND_BITS-1:0] island_sel;
    logic [ROW_BITS-1:0]    row_addr;
    logic [COL_BITS-1:0]    col_addr;
    logic decode_en, prog_mode, drain_sel_en;
    logic vinj_pulse, vtun_pulse, meas_en, busy;

    fg_prog_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .island_sel   (island_sel),
        .row_addr     (row_addr),
        .col_addr     (col_addr),
        .decode_en    (decode_en),
        .prog_mode    (prog_mode),
        .drain_sel_en (drain_sel_en),
        .vinj_pulse   (vinj_pulse),
        .vtun_pulse   (vtun_pulse),
        .meas_en      (meas_en),
        .busy         (busy)
    );

    int checks = 0;
    int failures = 0;
    logic [127:0] t_inj, t_tun, t_meas, t_dse, t_dec, t_prog;
    logic [127:0] ep;
    int rsp_cyc;
    logic stable;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rec(input int c);
        t_inj[c]  = vinj_pulse;
        t_tun[c]  = vtun_pulse;
        t_meas[c] = meas_en;
        t_dse[c]  = drain_sel_en;
        t_dec[c]  = decode_en;
        t_prog[c] = prog_mode;
        if (bus.rsp_valid && rsp_cyc < 0) rsp_cyc = c;
    endtask

    task automatic start_trace();
        t_inj = '0; t_tun = '0; t_meas = '0;
        t_dse = '0; t_dec = '0; t_prog = '0;
        rsp_cyc = -1;
        rec(0);
    endtask

    task automatic issue(input logic [1:0] m, input int row, input int col,
                         input int len, input int cnt);
        int n;
        bus.cmd_island    = '0;
        bus.cmd_row       = ROW_BITS'(row);
        bus.cmd_col       = COL_BITS'(col);
        bus.cmd_mode      = m;
        bus.cmd_pulse_len = PULSE_W'(len);
        bus.cmd_pulse_cnt = COUNT_W'(cnt);
        bus.cmd_valid     = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("cmd_ready_timeout", 0, 1);
        tick();
        bus.cmd_valid = 1'b0;
        start_trace();
    endtask

    task automatic run(input int ncyc, input int abort_at);
        for (int c = 1; c <= ncyc; c++) begin
            if (c == abort_at) bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
            rec(c);
        end
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    // Pulse k (0-based) is high on cycles 17+k*(len+8) .. +len-1.
    function automatic logic [127:0] exp_pat(input int n, input int len);
        logic [127:0] p = '0;
        for (int k = 0; k < n; k++)
            for (int j = 0; j < len; j++)
                if (17 + k * (len + 8) + j < 128)
                    p[17 + k * (len + 8) + j] = 1'b1;
        return p;
    endfunction

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 0; bus.cmd_island = 0; bus.cmd_row = 0;
        bus.cmd_col = 0; bus.cmd_mode = 0; bus.cmd_pulse_len = 0;
        bus.cmd_pulse_cnt = 0; bus.abort = 0; bus.rsp_ready = 0;
        tick();
        tick();
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_prog", prog_mode, 0);
        rst = 1'b0;
        check("rel_cmd_ready", bus.cmd_ready, 0);
        tick();
        check("first_cmd_ready", bus.cmd_ready, 1);

        // Inject: three 4-cycle pulses
        issue(MODE_INJ, 5, 12, 4, 3);
        check("t1_row", row_addr, 5);
        check("t1_col", col_addr, 12);
        check("t1_dec0", decode_en, 1);
        check("t1_prog0", prog_mode, 1);
        check("t1_busy", busy, 1);
        check("t1_ready0", bus.cmd_ready, 0);
        run(60, 0);
        check("t1_vinj", t_inj, exp_pat(3, 4));
        check("t1_vtun", t_tun, 0);
        check("t1_rsp_cyc", rsp_cyc, 53);
        check("t1_dse", t_dse[52:0], {53{1'b1}});
        check("t1_status", bus.rsp_status, ST_OK);
        check("t1_pulses", bus.rsp_pulses, 3);
        check("t1_resp_prog", prog_mode, 0);
        check("t1_resp_dec", decode_en, 0);
        check("t1_row_hold", row_addr, 5);
        take_rsp();
        check("t1_rsp_drop", bus.rsp_valid, 0);
        check("t1_idle_ready", bus.cmd_ready, 1);

        // Tunnel: one 10-cycle pulse, no drain select
        issue(MODE_TUN, 1, 2, 10, 1);
        run(40, 0);
        check("t2_vtun", t_tun, exp_pat(1, 10));
        check("t2_vinj", t_inj, 0);
        check("t2_dse", t_dse, 0);
        check("t2_rsp_cyc", rsp_cyc, 35);
        check("t2_prog_last", t_prog[34], 1);
        check("t2_prog_resp", t_prog[35], 0);
        check("t2_status", bus.rsp_status, ST_OK);
        check("t2_pulses", bus.rsp_pulses, 1);
        take_rsp();

        // Illegal mode
        issue(MODE_ILL, 3, 4, 4, 3);
        run(5, 0);
        check("t3a_rsp_cyc", rsp_cyc, 0);
        check("t3a_dec", t_dec, 0);
        check("t3a_strb", t_inj | t_tun | t_meas, 0);
        check("t3a_status", bus.rsp_status, ST_ILLEGAL);
        check("t3a_pulses", bus.rsp_pulses, 0);
        take_rsp();

        // Inject with zero length
        issue(MODE_INJ, 3, 4, 0, 3);
        run(5, 0);
        check("t3b_rsp_cyc", rsp_cyc, 0);
        check("t3b_dec", t_dec, 0);
        check("t3b_prog", t_prog, 0);
        check("t3b_strb", t_inj | t_tun | t_meas, 0);
        check("t3b_status", bus.rsp_status, ST_ILLEGAL);
        take_rsp();

        // Zero pulse count: response straight after settle
        issue(MODE_INJ, 3, 3, 5, 0);
        run(20, 0);
        check("tc0_rsp_cyc", rsp_cyc, 17);
        check("tc0_strb", t_inj | t_tun | t_meas, 0);
        check("tc0_status", bus.rsp_status, ST_OK);
        check("tc0_pulses", bus.rsp_pulses, 0);
        take_rsp();

        // Abort 5 cycles into the third 20-cycle pulse
        issue(MODE_INJ, 7, 9, 20, 5);
        run(95, 78);
        ep = exp_pat(2, 20);
        for (int j = 73; j < 78; j++) ep[j] = 1'b1;
        check("t4_vinj", t_inj, ep);
        check("t4_rsp_cyc", rsp_cyc, 86);
        check("t4_drain_prog", t_prog[85], 1);
        check("t4_drain_dec", t_dec[85], 1);
        check("t4_status", bus.rsp_status, ST_ABORT);
        check("t4_pulses", bus.rsp_pulses, 2);
        take_rsp();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t4_idle_abort", {busy, bus.cmd_ready}, 2'b01);

        // Measure then back-pressure
        issue(MODE_MEAS, 2, 4, 2, 1);
        run(30, 0);
        check("t5_meas", t_meas, exp_pat(1, 2));
        check("t5_dse", t_dse[26:0], {27{1'b1}});
        check("t5_rsp_cyc", rsp_cyc, 27);
        bus.cmd_row = 6'd9; bus.cmd_col = 6'd1;
        bus.cmd_mode = MODE_INJ; bus.cmd_pulse_len = 16'd1;
        bus.cmd_pulse_cnt = 8'd1; bus.cmd_valid = 1'b1;
        bus.abort = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(bus.rsp_valid && bus.rsp_status == ST_OK &&
                  bus.rsp_pulses == 1 && !bus.cmd_ready && busy))
                stable = 1'b0;
        end
        bus.abort = 1'b0;
        check("t5_hold", stable, 1);
        take_rsp();
        check("t5_h_ready", bus.cmd_ready, 1);
        check("t5_h_busy", busy, 0);
        tick();
        bus.cmd_valid = 1'b0;
        check("t5_acc_busy", busy, 1);
        check("t5_acc_row", row_addr, 9);
        start_trace();
        run(30, 0);
        check("t5_vinj", t_inj, exp_pat(1, 1));
        check("t5_rsp2_cyc", rsp_cyc, 26);
        take_rsp();

        // Asynchronous reset mid-pulse
        issue(MODE_INJ, 6, 6, 20, 2);
        run(20, 0);
        check("t6_pre_vinj", vinj_pulse, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_vinj", vinj_pulse, 0);
        check("t6_ctl", {decode_en, prog_mode, drain_sel_en, busy}, 0);
        check("t6_hs", {bus.cmd_ready, bus.rsp_valid}, 0);
        check("t6_row", row_addr, 0);
        tick();
        rst = 1'b0;
        check("t6_rel_ready", bus.cmd_ready, 0);
        tick();
        check("t6_ready", bus.cmd_ready, 1);
        issue(MODE_TUN, 1, 1, 3, 2);
        run(45, 0);
        check("t6_vtun", t_tun, exp_pat(2, 3));
        check("t6_rsp_cyc", rsp_cyc, 39);
        check("t6_pulses", bus.rsp_pulses, 2);
        take_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fg_prog_sequencer.md
Name: fg_prog_sequencer

Overview:
Digital sequencer for the FPAA floating-gate programming infrastructure.
- Accepts programming commands (island, row, column, mode, pulse length, pulse count) over a valid/ready handshake.
- Drives the row/column decoder addresses, the PROG/RUN selection, drain-select enable and the injection/tunnelling pulse strobes, with fixed settle and recover intervals.
- Returns one status response per command.
- Sits between the host programming interface and the per-island VinjDecode, drain-select and indirect-switch tiles.

Parameters:
ISLAND_BITS, 1, width of island select
ROW_BITS, 6, width of vertical decoder address
COL_BITS, 6, width of horizontal decoder address
PULSE_W, 16, width of pulse-length field, in clk cycles
COUNT_W, 8, width of pulse-count field
SETTLE_CYCLES, 16, address/mode settle time before the first pulse
RECOVER_CYCLES, 8, gap after each pulse

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_island  in  ISLAND_BITS  target island
cmd_row  in  ROW_BITS  target row
cmd_col  in  COL_BITS  target column
cmd_mode  in  2  00 inject, 01 tunnel, 10 measure, 11 illegal
cmd_pulse_len  in  PULSE_W  pulse high time in cycles
cmd_pulse_cnt  in  COUNT_W  number of pulses
abort  in  1  terminate the current command
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_status  out  2  00 ok, 01 aborted, 10 illegal
rsp_pulses  out  COUNT_W  pulses actually issued
island_sel  out  ISLAND_BITS  registered island
row_addr  out  ROW_BITS  vertical decoder address
col_addr  out  COL_BITS  horizontal decoder address
decode_en  out  1  decoders enabled
prog_mode  out  1  1 = PROG, 0 = RUN
drain_sel_en  out  1  drain-select enable (inject and measure modes)
vinj_pulse  out  1  injection strobe
vtun_pulse  out  1  tunnelling strobe
meas_en  out  1  measurement window
busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous, immediate. All outputs go to 0, including prog_mode (RUN) and cmd_ready. FSM enters IDLE. cmd_ready rises on the first clock edge after rst deasserts.
- The FSM has seven states: IDLE, SETUP, SETTLE, PULSE, RECOVER, RESP, DRAIN.
- IDLE
  - cmd_ready = 1.
  - On handshake, latch every cmd field.
  - If cmd_mode = 11 or cmd_pulse_len = 0 (in non-measure modes), go to RESP with status 10 and rsp_pulses 0. No outputs toggle.
  - Otherwise go to SETUP.
- SETUP, 1 cycle
  - Drive island_sel, row_addr, col_addr.
  - decode_en = 1, prog_mode = 1.
  - drain_sel_en = 1 in inject and measure modes, 0 in tunnel mode.
  - Go to SETTLE.
- SETTLE
  - Counts SETTLE_CYCLES cycles, then goes to PULSE.
  - If cmd_pulse_cnt = 0, go directly to RESP with status 00 and rsp_pulses 0.
- PULSE
  - Inject mode: vinj_pulse = 1. Tunnel mode: vtun_pulse = 1. Measure mode: meas_en = 1.
  - The strobe stays high for exactly cmd_pulse_len cycles; measure mode uses the same length.
  - Then increment the pulse counter and go to RECOVER.
- RECOVER
  - All strobes 0 for RECOVER_CYCLES cycles.
  - If pulses issued == cmd_pulse_cnt, go to RESP; otherwise go to PULSE.
  - Addresses stay stable for the whole command.
- RESP
  - decode_en, drain_sel_en and prog_mode return to 0 on entry.
  - rsp_valid = 1 and holds until rsp_ready.
  - Handshake returns to IDLE. cmd_ready is 0 until then; no command queue.
- Abort
  - abort high in SETUP, SETTLE, PULSE or RECOVER forces all strobes low the next cycle and enters DRAIN.
  - DRAIN holds addresses and holds prog_mode = 1 for RECOVER_CYCLES with strobes low, then enters RESP with status 01.
  - rsp_pulses counts only fully completed pulses. A pulse truncated by abort is not counted.
  - abort in IDLE or RESP is ignored.
- Strobe safety: vinj_pulse and vtun_pulse are never high in the same cycle. Strobes are high only while prog_mode = 1 and decode_en = 1. Every strobe is a registered output.
- Counters are COUNT_W / PULSE_W wide with no wrap. Terminal comparisons use ==, and the loaded value never exceeds the field max.
- Timing
  - First strobe rises exactly 1 + SETTLE_CYCLES cycles after the accept edge.
  - Response latency for N pulses of length L: 1 + SETTLE + N·(L + RECOVER) cycles from accept to rsp_valid.

Decomposition:
- Shared package fg_prog_pkg holds:
  - mode enum: MODE_INJ, MODE_TUN, MODE_MEAS, MODE_ILL
  - status enum: ST_OK, ST_ABORT, ST_ILLEGAL
  - FSM state enum
  - a command struct bundling the cmd fields
- One sub-module, fg_prog_timer: loadable down-counter with a done flag. Used for the settle, pulse-length and recover intervals.

Test Plan:
1. Inject: row 5, col 12, len 4, cnt 3, defaults → vinj_pulse three 4-cycle highs separated by 8-cycle gaps. First rise 17 cycles after accept. rsp_valid at cycle 53, status 00, rsp_pulses 3. vtun_pulse stays 0.
2. Tunnel: cnt 1, len 10 → drain_sel_en 0 throughout, one 10-cycle vtun_pulse, status 00, prog_mode back to 0 in RESP.
3. Illegal: mode 11 → no decode_en or strobe activity, rsp status 10, rsp_pulses 0. Repeat with inject mode and len 0 → same result.
4. Abort: inject, cnt 5, len 20; abort pulsed 5 cycles into the third pulse → strobe low the next cycle, RECOVER_CYCLES of drain, status 01, rsp_pulses 2.
5. Back-pressure: hold rsp_ready 0 for 10 cycles → rsp_valid and fields stable, cmd_ready 0. A cmd_valid offered meanwhile is not accepted until the cycle after the rsp handshake.
6. Reset mid-PULSE: assert rst asynchronously while vinj_pulse = 1 → all outputs 0 without waiting for a clock edge. After release, cmd_ready = 1 and the next command runs normally.
